// File: rtl/rrat.sv
// Retirement register alias table: committed arch->phys map with a one-entry free-list output.
// Optional consistency checker enabled by defining RRAT_CHECK_EN.
module rrat #(
  parameter int unsigned ARCH_REGS = 32,
  parameter int unsigned PHYS_W    = 6
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_commit_valid,
  output logic                          o_commit_ready,
  input  logic                          i_commit_regf_we,
  input  logic [$clog2(ARCH_REGS)-1:0]  i_commit_rd_arch,
  input  logic [PHYS_W-1:0]             i_commit_rd_phys,
  input  logic                          i_flush,
  output logic                          o_free_enqueue,
  output logic [PHYS_W-1:0]             o_free_wdata,
  input  logic                          i_free_full,
  output logic [ARCH_REGS*PHYS_W-1:0]   o_rrat_map,
  output logic                          o_rrat_error
);

  logic [PHYS_W-1:0] r_table [ARCH_REGS];
  logic              r_free_enqueue;
  logic [PHYS_W-1:0] r_free_wdata;

  logic              w_taken;
  logic              w_accept;
  logic              w_remap;
  logic [PHYS_W-1:0] w_old;

  assign w_taken        = r_free_enqueue && !i_free_full;
  assign o_commit_ready = !(r_free_enqueue && i_free_full);
  assign w_accept       = i_commit_valid && o_commit_ready && !i_flush;
  assign w_remap        = w_accept && i_commit_regf_we && (i_commit_rd_arch != '0);
  assign w_old          = r_table[i_commit_rd_arch];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < int'(ARCH_REGS); i++) begin
        r_table[i] <= PHYS_W'(i);
      end
    end else if (w_remap) begin
      r_table[i_commit_rd_arch] <= i_commit_rd_phys;
    end
  end

  // A remap reloads the output slot; it is only reachable when the slot is empty or being taken.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_free_enqueue <= 1'b0;
      r_free_wdata   <= '0;
    end else if (w_remap) begin
      r_free_enqueue <= 1'b1;
      r_free_wdata   <= w_old;
    end else if (w_taken) begin
      r_free_enqueue <= 1'b0;
    end
  end

  assign o_free_enqueue = r_free_enqueue;
  assign o_free_wdata   = r_free_wdata;

  always_comb begin
    o_rrat_map = '0;
    for (int i = 0; i < int'(ARCH_REGS); i++) begin
      o_rrat_map[i*PHYS_W +: PHYS_W] = r_table[i];
    end
  end

`ifdef RRAT_CHECK_EN
  localparam int unsigned NumPhys = 2 ** PHYS_W;

  logic [NumPhys-1:0] r_mapped;
  logic               r_error;
  logic               w_conflict;

  assign w_conflict = r_mapped[i_commit_rd_phys] && (i_commit_rd_phys != w_old);

  // Clear-then-set ordering keeps the bit set when a commit remaps to the same phys.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < int'(NumPhys); i++) begin
        r_mapped[i] <= (i < int'(ARCH_REGS));
      end
      r_error <= 1'b0;
    end else if (w_remap) begin
      r_mapped[w_old]            <= 1'b0;
      r_mapped[i_commit_rd_phys] <= 1'b1;
      if (w_conflict) begin
        r_error <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && w_remap) begin
      assert (!w_conflict) else $error("rrat: phys %0d already mapped", i_commit_rd_phys);
    end
  end

  assign o_rrat_error = r_error;
`else
  assign o_rrat_error = 1'b0;
`endif

endmodule

// File: tb/tb_rrat.sv
// Self-checking bench for rrat: scoreboard of expected freed phys regs plus a reference map.
module tb_rrat;

  logic         clk;
  logic         rst;
  logic         commit_valid;
  logic         commit_ready;
  logic         commit_regf_we;
  logic [4:0]   commit_rd_arch;
  logic [5:0]   commit_rd_phys;
  logic         flush;
  logic         free_enqueue;
  logic [5:0]   free_wdata;
  logic         free_full;
  logic [191:0] rrat_map;
  logic         rrat_error;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  logic [5:0] m_table [32];
  logic [5:0] exp_q [$];

  rrat #(
    .ARCH_REGS(32),
    .PHYS_W   (6)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_commit_valid  (commit_valid),
    .o_commit_ready  (commit_ready),
    .i_commit_regf_we(commit_regf_we),
    .i_commit_rd_arch(commit_rd_arch),
    .i_commit_rd_phys(commit_rd_phys),
    .i_flush         (flush),
    .o_free_enqueue  (free_enqueue),
    .o_free_wdata    (free_wdata),
    .i_free_full     (free_full),
    .o_rrat_map      (rrat_map),
    .o_rrat_error    (rrat_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [191:0] exp_map();
    logic [191:0] v;
    for (int i = 0; i < 32; i++) v[i*6 +: 6] = m_table[i];
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_table[i] = 6'(i);
    exp_q.delete();
  endfunction

  // Scoreboard: every take of the output slot must match the oldest expected free.
  always @(negedge clk) begin
    if (!rst && free_enqueue && !free_full) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL free_take: unexpected free of %0d, none expected", free_wdata);
      end else begin
        if (free_wdata !== exp_q[0]) begin
          n_err++;
          $display("FAIL free_take: got %0d expected %0d", free_wdata, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic do_commit(input logic we, input logic [4:0] rd, input logic [5:0] phys);
    commit_valid   = 1'b1;
    commit_regf_we = we;
    commit_rd_arch = rd;
    commit_rd_phys = phys;
    @(negedge clk);
    n_chk++;
    if (commit_ready !== 1'b1) begin
      n_err++;
      $display("FAIL commit_ready: got %b expected 1 (rd=%0d)", commit_ready, rd);
    end
    @(posedge clk);
    if (we && rd != 5'd0) begin
      exp_q.push_back(m_table[rd]);
      m_table[rd] = phys;
    end
    #1;
    commit_valid   = 1'b0;
    commit_regf_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (rrat_map !== exp_map()) begin
      n_err++;
      $display("FAIL reset_map: got %h expected %h", rrat_map, exp_map());
    end
    n_chk++;
    if ({free_enqueue, free_wdata, commit_ready, rrat_error} !== {1'b0, 6'd0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL reset_outputs: got enq=%b wdata=%0d rdy=%b err=%b expected 0 0 1 0",
               free_enqueue, free_wdata, commit_ready, rrat_error);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_remap();
    do_commit(1'b1, 5'd5, 6'd40);
    n_chk++;
    if (free_enqueue !== 1'b1 || free_wdata !== 6'd5) begin
      n_err++;
      $display("FAIL remap_first: got enq=%b wdata=%0d expected 1 5", free_enqueue, free_wdata);
    end
    n_chk++;
    if (rrat_map[5*6 +: 6] !== 6'd40) begin
      n_err++;
      $display("FAIL remap_entry5: got %0d expected 40", rrat_map[5*6 +: 6]);
    end
    do_commit(1'b1, 5'd5, 6'd41);
    n_chk++;
    if (free_enqueue !== 1'b1 || free_wdata !== 6'd40) begin
      n_err++;
      $display("FAIL remap_b2b: got enq=%b wdata=%0d expected 1 40", free_enqueue, free_wdata);
    end
    n_chk++;
    if (rrat_map !== exp_map()) begin
      n_err++;
      $display("FAIL remap_map: got %h expected %h", rrat_map, exp_map());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_no_remap();
    do_commit(1'b1, 5'd0, 6'd33);
    do_commit(1'b0, 5'd9, 6'd44);
    n_chk++;
    if (free_enqueue !== 1'b0) begin
      n_err++;
      $display("FAIL no_remap_enq: got %b expected 0", free_enqueue);
    end
    n_chk++;
    if (rrat_map !== exp_map()) begin
      n_err++;
      $display("FAIL no_remap_map: got %h expected %h", rrat_map, exp_map());
    end
  endtask

  task automatic test_hold();
    do_commit(1'b1, 5'd7, 6'd50);
    free_full      = 1'b1;
    commit_valid   = 1'b1;
    commit_regf_we = 1'b1;
    commit_rd_arch = 5'd8;
    commit_rd_phys = 6'd51;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_chk++;
      if (commit_ready !== 1'b0 || free_enqueue !== 1'b1 || free_wdata !== 6'd7) begin
        n_err++;
        $display("FAIL hold_cycle%0d: got rdy=%b enq=%b wdata=%0d expected 0 1 7",
                 c, commit_ready, free_enqueue, free_wdata);
      end
    end
    @(posedge clk);
    #1 free_full = 1'b0;
    @(negedge clk);
    n_chk++;
    if (commit_ready !== 1'b1) begin
      n_err++;
      $display("FAIL hold_release_ready: got %b expected 1", commit_ready);
    end
    @(posedge clk);
    exp_q.push_back(m_table[8]);
    m_table[8] = 6'd51;
    #1;
    commit_valid   = 1'b0;
    commit_regf_we = 1'b0;
    n_chk++;
    if (free_enqueue !== 1'b1 || free_wdata !== 6'd8) begin
      n_err++;
      $display("FAIL hold_no_bubble: got enq=%b wdata=%0d expected 1 8", free_enqueue, free_wdata);
    end
    n_chk++;
    if (rrat_map !== exp_map()) begin
      n_err++;
      $display("FAIL hold_map: got %h expected %h", rrat_map, exp_map());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_flush();
    do_commit(1'b1, 5'd4, 6'd52);
    flush          = 1'b1;
    commit_valid   = 1'b1;
    commit_regf_we = 1'b1;
    commit_rd_arch = 5'd3;
    commit_rd_phys = 6'd50;
    @(posedge clk);
    #1;
    flush          = 1'b0;
    commit_valid   = 1'b0;
    commit_regf_we = 1'b0;
    n_chk++;
    if (rrat_map[3*6 +: 6] !== 6'd3) begin
      n_err++;
      $display("FAIL flush_entry3: got %0d expected 3", rrat_map[3*6 +: 6]);
    end
    n_chk++;
    if (free_enqueue !== 1'b0) begin
      n_err++;
      $display("FAIL flush_enq: got %b expected 0", free_enqueue);
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL flush_pending_delivered: got %0d outstanding expected 0", exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    do_commit(1'b1, 5'd10, 6'd53);
    free_full = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_chk++;
    if (free_enqueue !== 1'b0) begin
      n_err++;
      $display("FAIL async_rst_enq: got %b expected 0", free_enqueue);
    end
    n_chk++;
    if (rrat_map !== exp_map()) begin
      n_err++;
      $display("FAIL async_rst_map: got %h expected %h", rrat_map, exp_map());
    end
    free_full = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_check();
    do_commit(1'b1, 5'd1, 6'd40);
    do_commit(1'b1, 5'd2, 6'd40);
`ifdef RRAT_CHECK_EN
    n_chk++;
    if (rrat_error !== 1'b1) begin
      n_err++;
      $display("FAIL check_set: got %b expected 1", rrat_error);
    end
    do_commit(1'b1, 5'd6, 6'd60);
    do_commit(1'b1, 5'd11, 6'd61);
    n_chk++;
    if (rrat_error !== 1'b1) begin
      n_err++;
      $display("FAIL check_sticky: got %b expected 1", rrat_error);
    end
`else
    n_chk++;
    if (rrat_error !== 1'b0) begin
      n_err++;
      $display("FAIL check_disabled: got %b expected 0", rrat_error);
    end
`endif
    n_chk++;
    if (rrat_map !== exp_map()) begin
      n_err++;
      $display("FAIL check_map: got %h expected %h", rrat_map, exp_map());
    end
  endtask

  initial begin
    rst            = 1'b1;
    commit_valid   = 1'b0;
    commit_regf_we = 1'b0;
    commit_rd_arch = '0;
    commit_rd_phys = '0;
    flush          = 1'b0;
    free_full      = 1'b0;
    #1;
    test_reset();
    test_remap();
    test_no_remap();
    test_hold();
    test_flush();
    test_async_reset();
    test_check();
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d outstanding frees expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
